// File: rtl/qvga_quad_reader.sv
// qvga_quad_reader
//
// Pixel-fetch stage ahead of the image filter. It reads a double-buffered
// IMG_WIDTH x IMG_HEIGHT RGB444 camera frame from a synchronous-read BRAM and
// shows it 2x upscaled in the bottom-right quadrant of the VGA raster. The
// VGA timing controls are re-timed so that they stay aligned with the fetched
// pixel. Total latency from inputs to outputs is two clocks.
//
// The module also owns the ping-pong bank swap. A finished camera frame is only
// handed to the display at the first blanking line, so the banks never change
// while active video is being drawn.
//
// Ports:
//   clk            pixel clock
//   reset          asynchronous reset, active low
//   DE_in          data enable from the sync generator
//   x_pixel_in     VGA column (10 bits)
//   y_pixel_in     VGA row (10 bits)
//   h_sync_in      horizontal sync
//   v_sync_in      vertical sync
//   wr_frame_done  one-cycle pulse: the camera writer has finished wr_bank
//   rd_addr        frame-buffer read address (local_y*IMG_WIDTH + local_x)
//   rd_bank        bank currently being displayed
//   wr_bank        bank the camera writer fills; always ~rd_bank
//   rd_data        BRAM read data {R,G,B}, sampled by the second stage
//   DE, x_pixel, y_pixel, h_sync, v_sync   inputs delayed by two clocks
//   r_out, g_out, b_out                    pixel colour aligned with DE/x/y
module qvga_quad_reader #(
  parameter int          IMG_WIDTH  = 160,
  parameter int          IMG_HEIGHT = 120,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DE_in,
  input  logic [9:0]  x_pixel_in,
  input  logic [9:0]  y_pixel_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        wr_frame_done,
  output logic [14:0] rd_addr,
  output logic        rd_bank,
  output logic        wr_bank,
  input  logic [11:0] rd_data,
  output logic        DE,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        h_sync,
  output logic        v_sync,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);

  // The quadrant origin follows from the 2x upscale: the image covers the
  // last 2*IMG_WIDTH columns and the last 2*IMG_HEIGHT rows.
  localparam logic [9:0] QUAD_X0  = 10'(H_ACTIVE - 2 * IMG_WIDTH);
  localparam logic [9:0] QUAD_Y0  = 10'(V_ACTIVE - 2 * IMG_HEIGHT);
  localparam logic [9:0] H_LIMIT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIMIT  = 10'(V_ACTIVE);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } swapState_t;

  logic        w_inQuad;
  logic [9:0]  w_localX;
  logic [9:0]  w_localY;
  logic [14:0] w_addr;
  logic        w_atBlankLine;
  logic        w_swapEvent;
  logic        w_doSwap;

  logic [14:0] r_rdAddr;
  logic        r_deS1;
  logic [9:0]  r_xS1;
  logic [9:0]  r_yS1;
  logic        r_hSyncS1;
  logic        r_vSyncS1;
  logic        r_inQuadS1;

  logic        r_deS2;
  logic [9:0]  r_xS2;
  logic [9:0]  r_yS2;
  logic        r_hSyncS2;
  logic        r_vSyncS2;
  logic [11:0] r_rgbS2;

  logic        r_atBlankPrev;
  logic        r_rdBank;
  swapState_t  r_state;
  swapState_t  w_stateNext;

  // Quadrant test and source-pixel address. Halving the offset gives the 2x
  // upscale. local_y*160 is built as (local_y<<7)+(local_y<<5) so that no
  // multiplier is needed. Outside the quadrant the offsets are meaningless,
  // so the address is forced to 0 in the register stage.
  always_comb begin
    w_inQuad = (x_pixel_in >= QUAD_X0) && (y_pixel_in >= QUAD_Y0) &&
               (x_pixel_in <  H_LIMIT) && (y_pixel_in <  V_LIMIT);
    w_localX = (x_pixel_in - QUAD_X0) >> 1;
    w_localY = (y_pixel_in - QUAD_Y0) >> 1;
    w_addr   = ({5'd0, w_localY} << 7) + ({5'd0, w_localY} << 5) + {5'd0, w_localX};
  end

  // Stage 1: issue the BRAM address and register the controls that go with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdAddr   <= '0;
      r_deS1     <= 1'b0;
      r_xS1      <= '0;
      r_yS1      <= '0;
      r_hSyncS1  <= 1'b0;
      r_vSyncS1  <= 1'b0;
      r_inQuadS1 <= 1'b0;
    end else begin
      r_rdAddr   <= w_inQuad ? w_addr : 15'd0;
      r_deS1     <= DE_in;
      r_xS1      <= x_pixel_in;
      r_yS1      <= y_pixel_in;
      r_hSyncS1  <= h_sync_in;
      r_vSyncS1  <= v_sync_in;
      r_inQuadS1 <= w_inQuad;
    end
  end

  // Stage 2: pick the colour. The BRAM data for the stage-1 address is
  // available now. Blanked pixels are always black, and active pixels
  // outside the quadrant get the background colour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deS2    <= 1'b0;
      r_xS2     <= '0;
      r_yS2     <= '0;
      r_hSyncS2 <= 1'b0;
      r_vSyncS2 <= 1'b0;
      r_rgbS2   <= '0;
    end else begin
      r_deS2    <= r_deS1;
      r_xS2     <= r_xS1;
      r_yS2     <= r_yS1;
      r_hSyncS2 <= r_hSyncS1;
      r_vSyncS2 <= r_vSyncS1;
      if (!r_deS1)
        r_rgbS2 <= 12'h000;
      else if (r_inQuadS1)
        r_rgbS2 <= rd_data;
      else
        r_rgbS2 <= BG_COLOR;
    end
  end

  // The swap event is the first cycle of the first blanking line. The
  // edge detect makes sure it fires only once per frame, even though
  // y stays at V_ACTIVE for a whole line.
  assign w_atBlankLine = (y_pixel_in == V_LIMIT);
  assign w_swapEvent   = w_atBlankLine && !r_atBlankPrev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_atBlankPrev <= 1'b0;
    else
      r_atBlankPrev <= w_atBlankLine;
  end

  // Swap FSM state register. A reset discards any swap that is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_stateNext;
  end

  // Swap FSM next state. A frame-done pulse that arrives at the same time as
  // the swap event is handled right away, so the FSM stays in IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:    if (wr_frame_done && !w_swapEvent) w_stateNext = ST_PENDING;
      ST_PENDING: if (w_swapEvent) w_stateNext = ST_IDLE;
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  // Swap FSM output: toggle the banks when a completed frame meets the
  // swap event.
  always_comb begin
    w_doSwap = 1'b0;
    case (r_state)
      ST_IDLE:    w_doSwap = wr_frame_done && w_swapEvent;
      ST_PENDING: w_doSwap = w_swapEvent;
      default:    w_doSwap = 1'b0;
    endcase
  end

  // Displayed bank register. The write bank is derived from it, so the two
  // banks can never point at the same buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rdBank <= 1'b0;
    else if (w_doSwap)
      r_rdBank <= ~r_rdBank;
  end

  assign rd_addr = r_rdAddr;
  assign rd_bank = r_rdBank;
  assign wr_bank = ~r_rdBank;
  assign DE      = r_deS2;
  assign x_pixel = r_xS2;
  assign y_pixel = r_yS2;
  assign h_sync  = r_hSyncS2;
  assign v_sync  = r_vSyncS2;
  assign r_out   = r_rgbS2[11:8];
  assign g_out   = r_rgbS2[7:4];
  assign b_out   = r_rgbS2[3:0];

endmodule

// File: tb/tb_qvga_quad_reader.sv
// tb_qvga_quad_reader
//
// Directed bench for qvga_quad_reader. The inputs change 1 ns after each
// rising edge, and the outputs are sampled at the same point, so sampling
// never happens on the active edge. The expected values are computed by hand.
module tb_qvga_quad_reader;

  logic        clk;
  logic        reset;
  logic        DE_in;
  logic [9:0]  x_pixel_in;
  logic [9:0]  y_pixel_in;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        wr_frame_done;
  logic [14:0] rd_addr;
  logic        rd_bank;
  logic        wr_bank;
  logic [11:0] rd_data;
  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        h_sync;
  logic        v_sync;
  logic [3:0]  r_out;
  logic [3:0]  g_out;
  logic [3:0]  b_out;

  int total;
  int bad;

  qvga_quad_reader dut (
    .clk           (clk),
    .reset         (reset),
    .DE_in         (DE_in),
    .x_pixel_in    (x_pixel_in),
    .y_pixel_in    (y_pixel_in),
    .h_sync_in     (h_sync_in),
    .v_sync_in     (v_sync_in),
    .wr_frame_done (wr_frame_done),
    .rd_addr       (rd_addr),
    .rd_bank       (rd_bank),
    .wr_bank       (wr_bank),
    .rd_data       (rd_data),
    .DE            (DE),
    .x_pixel       (x_pixel),
    .y_pixel       (y_pixel),
    .h_sync        (h_sync),
    .v_sync        (v_sync),
    .r_out         (r_out),
    .g_out         (g_out),
    .b_out         (b_out)
  );

  // 100 MHz free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one set of VGA-side inputs.
  task automatic applyStimulus(input logic de, input logic [9:0] x, input logic [9:0] y,
                               input logic hs, input logic vs, input logic wfd);
    DE_in         = de;
    x_pixel_in    = x;
    y_pixel_in    = y;
    h_sync_in     = hs;
    v_sync_in     = vs;
    wr_frame_done = wfd;
  endtask

  // One comparison point. Increments total, and increments bad on a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present a row value for one clock, with a write-done pulse if wfd is set.
  task automatic rowStep(input logic [9:0] y, input logic wfd);
    applyStimulus(1'b0, 10'd0, y, 1'b0, 1'b0, wfd);
    tick();
    wr_frame_done = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    rd_data = 12'h000;
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);

    // Reset held low for 5 cycles
    repeat (5) tick();
    checkOutput("rst_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_rdbank", 32'(rd_bank), 32'd0);
    checkOutput("rst_wrbank", 32'(wr_bank), 32'd1);
    checkOutput("rst_de", 32'(DE), 32'd0);
    checkOutput("rst_hs", 32'(h_sync), 32'd0);
    checkOutput("rst_rgb", 32'({r_out, g_out, b_out}), 32'h000);

    // Release with x=0, y=0, DE=1: background colour after two cycles
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("rel_addr", 32'(rd_addr), 32'd0);
    tick();
    checkOutput("rel_de", 32'(DE), 32'd1);
    checkOutput("rel_rgb", 32'({r_out, g_out, b_out}), 32'h000);

    // Corner addresses of the quadrant, with colour aligned two cycles later
    rd_data = 12'hABC;
    applyStimulus(1'b1, 10'd320, 10'd240, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("addr_first", 32'(rd_addr), 32'd0);
    applyStimulus(1'b1, 10'd639, 10'd479, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("addr_last", 32'(rd_addr), 32'd19199);
    checkOutput("rgb_first", 32'({r_out, g_out, b_out}), 32'hABC);
    checkOutput("x_first", 32'(x_pixel), 32'd320);
    checkOutput("y_first", 32'(y_pixel), 32'd240);
    checkOutput("hs_first", 32'(h_sync), 32'd1);
    applyStimulus(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rgb_last", 32'({r_out, g_out, b_out}), 32'hABC);
    checkOutput("x_last", 32'(x_pixel), 32'd639);
    checkOutput("y_last", 32'(y_pixel), 32'd479);
    checkOutput("vs_last", 32'(v_sync), 32'd1);

    // Horizontal scan: each source pixel is fetched for two columns
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 10'(320 + i), 10'd241, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("scan_y241", 32'(rd_addr), 32'(i / 2));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 10'(320 + i), 10'd243, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("scan_y243", 32'(rd_addr), 32'(160 + i / 2));
    end

    // Active pixel outside the quadrant gives the background colour
    rd_data = 12'hFFF;
    applyStimulus(1'b1, 10'd100, 10'd300, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("outq_addr", 32'(rd_addr), 32'd0);
    tick();
    checkOutput("outq_rgb", 32'({r_out, g_out, b_out}), 32'h000);
    // Inside the quadrant with DE high gives the BRAM data.
    // Address check: local (40,30) -> 30*160+40 = 4840
    applyStimulus(1'b1, 10'd400, 10'd300, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("inq_addr", 32'(rd_addr), 32'd4840);
    tick();
    checkOutput("inq_rgb", 32'({r_out, g_out, b_out}), 32'hFFF);
    // Inside the quadrant with DE low gives black
    applyStimulus(1'b0, 10'd400, 10'd300, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("blank_de", 32'(DE), 32'd0);
    checkOutput("blank_rgb", 32'({r_out, g_out, b_out}), 32'h000);

    // Swap: write-done mid-frame, banks flip only after the first y=480 cycle
    rowStep(10'd100, 1'b1);
    rowStep(10'd479, 1'b0);
    checkOutput("pend_rdbank", 32'(rd_bank), 32'd0);
    rowStep(10'd480, 1'b0);
    checkOutput("swap1_rdbank", 32'(rd_bank), 32'd1);
    checkOutput("swap1_wrbank", 32'(wr_bank), 32'd0);
    rowStep(10'd480, 1'b0);
    checkOutput("swap1_hold", 32'(rd_bank), 32'd1);

    // Next frame without write-done: no toggle
    rowStep(10'd0, 1'b0);
    rowStep(10'd480, 1'b0);
    rowStep(10'd480, 1'b0);
    checkOutput("noswap_rdbank", 32'(rd_bank), 32'd1);

    // Two write-done pulses in one frame: exactly one toggle
    rowStep(10'd10, 1'b1);
    rowStep(10'd20, 1'b1);
    rowStep(10'd480, 1'b0);
    checkOutput("dbl_rdbank", 32'(rd_bank), 32'd0);
    rowStep(10'd480, 1'b0);
    rowStep(10'd0, 1'b0);
    rowStep(10'd480, 1'b0);
    checkOutput("dbl_noextra", 32'(rd_bank), 32'd0);

    // Write-done coincident with the swap cycle from IDLE: swap immediately
    rowStep(10'd0, 1'b0);
    rowStep(10'd480, 1'b1);
    checkOutput("coin_rdbank", 32'(rd_bank), 32'd1);
    checkOutput("coin_wrbank", 32'(wr_bank), 32'd0);
    rowStep(10'd0, 1'b0);
    rowStep(10'd480, 1'b0);
    checkOutput("coin_idle", 32'(rd_bank), 32'd1);

    // Reset while PENDING: banks return to 0/1 and the pending swap is lost
    rowStep(10'd50, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("rstp_rdbank", 32'(rd_bank), 32'd0);
    checkOutput("rstp_wrbank", 32'(wr_bank), 32'd1);
    tick();
    applyStimulus(1'b0, 10'd0, 10'd50, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    rowStep(10'd480, 1'b0);
    rowStep(10'd480, 1'b0);
    checkOutput("rstp_noswap", 32'(rd_bank), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
